pcm_sample_fifo: RTL and testbench

Synchronous single-clock FIFO that buffers 16-bit PCM samples between the tone generator and the audio output serializer. It accepts one sample per cycle on a valid strobe and returns a registered read port. It drives the early `fifo_full` flag consumed by the tone generator. Optional overflow and underflow statistics are compiled in by macro.

---
 rtl/pcm_pkg.sv | 14 +
 rtl/pcm_fifo_mem.sv | 45 ++++
 rtl/pcm_sample_fifo.sv | 131 +++++++++++++
 tb/tb_pcm_sample_fifo.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/pcm_pkg.sv
// rtl/pcm_pkg.sv - shared PCM sample types and constants for the tone/serializer path
package pcm_pkg;

    localparam int PCM_WIDTH      = 16;
    localparam int PCM_STAT_WIDTH = 16;

    typedef logic [PCM_WIDTH-1:0] pcm_sample_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PCM_STAT_WIDTH-1:0] sat_inc(input logic [PCM_STAT_WIDTH-1:0] v);
        return (v == {PCM_STAT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pcm_fifo_mem.sv
// rtl/pcm_fifo_mem.sv - DEPTH x WIDTH simple dual-port sample store with registered read
//
// Ports:
//   clk_i               clock, rising edge
//   aclr_i              sync active-low reset (read register only; storage is not cleared)
//   wr_en_i/wr_addr_i/wr_data_i  write port
//   rd_en_i/rd_addr_i   read request
//   rd_data_o           registered read data, holds when no read
module pcm_fifo_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             aclr_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // When full with a simultaneous read and write, both addresses match;
    // the read returns the old entry, which is the correct FIFO order.
    always_ff @(posedge clk_i) begin
        if (!aclr_i) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pcm_sample_fifo.sv
// rtl/pcm_sample_fifo.sv - single-clock PCM sample FIFO with early-full flag
//
// Optional statistics: define PCM_FIFO_STATS_EN to build overflow/underflow counters.
//
// Ports:
//   clk, aclr (sync active-low reset)
//   wr_en, wr_data          producer write strobe and sample
//   fifo_full               registered early-full (free entries <= FULL_SLACK)
//   rd_en                   consumer read request
//   rd_data, rd_valid       registered read sample and its one-cycle valid
//   fifo_empty, level       registered occupancy status
//   overflow_cnt            dropped writes (0 when stats not built)
//   underflow_cnt           rejected reads (0 when stats not built)
module pcm_sample_fifo
    import pcm_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = PCM_WIDTH,
    parameter int FULL_SLACK = 2,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                      clk,
    input  logic                      aclr,
    input  logic                      wr_en,
    input  logic [WIDTH-1:0]          wr_data,
    output logic                      fifo_full,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      fifo_empty,
    output logic [LW-1:0]             level,
    output logic [PCM_STAT_WIDTH-1:0] overflow_cnt,
    output logic [PCM_STAT_WIDTH-1:0] underflow_cnt
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          rd_valid_q;
    logic          rd_ok, wr_ok, wr_drop, rd_reject;

    always_comb begin
        rd_ok     = rd_en && (level_q != '0);
        // A read at the same edge frees the slot, so a full FIFO still accepts.
        wr_ok     = wr_en && ((level_q != LW'(DEPTH)) || rd_ok);
        wr_drop   = wr_en && !wr_ok;
        rd_reject = rd_en && !rd_ok;

        wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        if (wr_ok && !rd_ok) begin
            level_d = level_q + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            level_d = level_q - 1'b1;
        end

        full_d  = (level_d >= LW'(DEPTH - FULL_SLACK));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            rd_valid_q <= rd_ok;
        end
    end

    pcm_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk_i     (clk),
        .aclr_i    (aclr),
        .wr_en_i   (wr_ok && aclr),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_ok && aclr),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_data)
    );

    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign level      = level_q;
    assign rd_valid   = rd_valid_q;

`ifdef PCM_FIFO_STATS_EN
    logic [PCM_STAT_WIDTH-1:0] ovf_q, ovf_d;
    logic [PCM_STAT_WIDTH-1:0] unf_q, unf_d;

    always_comb begin
        ovf_d = wr_drop   ? sat_inc(ovf_q) : ovf_q;
        unf_d = rd_reject ? sat_inc(unf_q) : unf_q;
    end

    always_ff @(posedge clk) begin
        if (!aclr) begin
            ovf_q <= '0;
            unf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign overflow_cnt  = ovf_q;
    assign underflow_cnt = unf_q;
`else
    logic unused_stats;
    assign unused_stats  = wr_drop ^ rd_reject;
    assign overflow_cnt  = '0;
    assign underflow_cnt = '0;
`endif

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// tb/tb_pcm_sample_fifo.sv - self-checking bench for pcm_sample_fifo
module tb_pcm_sample_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 16;
    localparam int LW    = 5;

    logic             clk = 1'b0;
    logic             aclr;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             fifo_full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             fifo_empty;
    logic [LW-1:0]    level;
    logic [15:0]      overflow_cnt;
    logic [15:0]      underflow_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcm_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FULL_SLACK(2)) dut (
        .clk           (clk),
        .aclr          (aclr),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .fifo_full     (fifo_full),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .fifo_empty    (fifo_empty),
        .level         (level),
        .overflow_cnt  (overflow_cnt),
        .underflow_cnt (underflow_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic a, input logic w, input logic [WIDTH-1:0] d, input logic r);
        aclr    = a;
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        a;
        logic        w;
        logic [15:0] d;
        logic        r;
        logic [4:0]  e_level;
        logic        e_full;
        logic        e_empty;
        logic        e_rv;
        logic [15:0] e_data;
    } vec_t;

    vec_t vecs[12];

    // Reference model for the hand-written sequences.
    logic [15:0] mq[$];
    logic [15:0] m_data;
    int          m_ovf;
    int          m_unf;

    task automatic mop(input string tag, input logic a, input logic w, input logic [15:0] d, input logic r);
        logic rok, wok;
        cycle(a, w, d, r);
        if (!a) begin
            mq.delete();
            m_data = '0;
            m_ovf  = 0;
            m_unf  = 0;
            rok    = 1'b0;
        end else begin
            rok = r && (mq.size() > 0);
            wok = w && (mq.size() < DEPTH || rok);
            if (rok) m_data = mq.pop_front();
            if (wok) mq.push_back(d);
            if (w && !wok) m_ovf++;
            if (r && !rok) m_unf++;
        end
        chk({tag, ".level"}, 32'(level), 32'(mq.size()));
        chk({tag, ".full"},  32'(fifo_full), 32'(mq.size() >= DEPTH - 2));
        chk({tag, ".empty"}, 32'(fifo_empty), 32'(mq.size() == 0));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(rok));
        chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_data));
`ifdef PCM_FIFO_STATS_EN
        chk({tag, ".ovf"}, 32'(overflow_cnt), 32'(m_ovf));
        chk({tag, ".unf"}, 32'(underflow_cnt), 32'(m_unf));
`else
        chk({tag, ".ovf"}, 32'(overflow_cnt), 32'd0);
        chk({tag, ".unf"}, 32'(underflow_cnt), 32'd0);
`endif
    endtask

    initial begin
        aclr = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0;

        //          a  w  data     r  lvl full emp rv data
        vecs[0]  = '{0, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h0000};
        vecs[1]  = '{1, 1, 16'h3F7F, 0, 1, 0, 0, 0, 16'h0000};
        vecs[2]  = '{1, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000};
        vecs[3]  = '{1, 0, 16'h0000, 0, 1, 0, 0, 0, 16'h0000};
        vecs[4]  = '{1, 0, 16'h0000, 1, 0, 0, 1, 1, 16'h3F7F};
        vecs[5]  = '{1, 0, 16'h0000, 0, 0, 0, 1, 0, 16'h3F7F};
        vecs[6]  = '{1, 1, 16'h1234, 0, 1, 0, 0, 0, 16'h3F7F};
        vecs[7]  = '{1, 1, 16'hBEEF, 1, 1, 0, 0, 1, 16'h1234};
        vecs[8]  = '{1, 0, 16'h0000, 1, 0, 0, 1, 1, 16'hBEEF};
        vecs[9]  = '{1, 0, 16'h0000, 1, 0, 0, 1, 0, 16'hBEEF};
        vecs[10] = '{1, 1, 16'h0001, 1, 1, 0, 0, 0, 16'hBEEF};
        vecs[11] = '{1, 0, 16'h0000, 1, 0, 0, 1, 1, 16'h0001};

        for (int i = 0; i < 12; i++) begin
            cycle(vecs[i].a, vecs[i].w, vecs[i].d, vecs[i].r);
            chk($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("vec%0d.full", i), 32'(fifo_full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d.empty", i), 32'(fifo_empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vecs[i].e_rv));
            chk($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].e_data));
        end

        // Fill: full must rise exactly at level 14, then run to 16 and drop 3.
        mop("rst_a", 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 16; i++) mop($sformatf("fill%0d", i), 1'b1, 1'b1, 16'(16'hA000 + i), 1'b0);
        chk("fill.level16", 32'(level), 32'd16);
        for (int i = 0; i < 3; i++) mop($sformatf("drop%0d", i), 1'b1, 1'b1, 16'hDEAD, 1'b0);
`ifdef PCM_FIFO_STATS_EN
        chk("drop.ovf3", 32'(overflow_cnt), 32'd3);
`endif
        // Full with read+write each cycle: level holds, data in order, no drops.
        for (int i = 0; i < 5; i++) mop($sformatf("rw%0d", i), 1'b1, 1'b1, 16'(16'hB000 + i), 1'b1);
        chk("rw.first_data", 32'(rd_data), 32'hA004);
        // Drain to level 9, then reset.
        for (int i = 0; i < 7; i++) mop($sformatf("drain%0d", i), 1'b1, 1'b0, 16'h0, 1'b1);
        chk("drain.level9", 32'(level), 32'd9);
        mop("rst_b", 1'b0, 1'b1, 16'h5555, 1'b1);
        mop("post_rst_rd", 1'b1, 1'b0, 16'h0, 1'b1);

        // Underflow: 4 rejected reads, write in the 4th is readable next.
        mop("rst_c", 1'b0, 1'b0, 16'h0, 1'b0);
        for (int i = 0; i < 3; i++) mop($sformatf("unf%0d", i), 1'b1, 1'b0, 16'h0, 1'b1);
        mop("unf3", 1'b1, 1'b1, 16'h7E57, 1'b1);
`ifdef PCM_FIFO_STATS_EN
        chk("unf.cnt4", 32'(underflow_cnt), 32'd4);
`endif
        mop("unf_rd", 1'b1, 1'b0, 16'h0, 1'b1);
        chk("unf_rd.data", 32'(rd_data), 32'h7E57);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
